// File: rtl/mul8_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
//
// Purpose : Shared types and constants for the sequential nibble multiplier
//           (mul8_seq_ctrl) and its 4x4 core.
//
// Contents:
//   state_t     - controller states IDLE / CALC / DONE
//   NIB_W       - width of one operand slice handled by the multiplier core
//   nib_count   - number of NIB_W slices in a DW-bit operand
//   nib_cnt_w   - width of a slice index counter (minimum 1 bit)
// ----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Number of nibbles making up one operand.
    function automatic int nib_count(input int dw);
        return dw / NIB_W;
    endfunction

    // Index counters need to address nib_count slices, but a zero-width
    // counter is not legal, so a single nibble still gets one bit.
    function automatic int nib_cnt_w(input int dw);
        int n;
        n = dw / NIB_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// mul8_seq_ctrl_if
//
// Purpose : Operand and result handshake bundle of the sequential multiplier.
//
// Signals :
//   in_valid  - producer presents an operand pair
//   in_ready  - controller can take an operand pair
//   a, b      - DW-bit unsigned operands
//   out_valid - controller presents a product
//   out_ready - consumer takes the product
//   product   - 2*DW-bit product
//   busy      - an operation is in flight or waiting to be taken
//
// Modports:
//   master - the producer/consumer side driving operands and out_ready
//   slave  - the multiplier controller
// ----------------------------------------------------------------------------
interface mul8_seq_ctrl_if #(
    parameter int DW = 8
);

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] product;
    logic            busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );

endinterface

// File: rtl/mul8_seq_ctrl_mul4.sv
// ----------------------------------------------------------------------------
// mul4_core
//
// Purpose : Purely combinational 4x4 unsigned multiplier built as a
//           shift-and-add of the four partial products of a by the bits of b.
//
// Ports   :
//   a [3:0] - multiplicand nibble
//   b [3:0] - multiplier nibble
//   p [7:0] - exact product a*b
// ----------------------------------------------------------------------------
module mul4_core
    import mul_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    logic [2*NIB_W-1:0] a_ext;

    // Partial product k is a gated by b[k], shifted left by k. The sum of
    // four such terms never exceeds 15*15, so 8 bits hold it exactly.
    always_comb begin
        a_ext = {{NIB_W{1'b0}}, a};
        p     = '0;
        for (int k = 0; k < NIB_W; k++) begin
            if (b[k]) begin
                p = p + (a_ext << k);
            end
        end
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mul8_seq_ctrl
//
// Purpose : Unsigned DW x DW multiplier that reuses one 4x4 combinational
//           core over (DW/4)^2 cycles. Operands are taken on a valid/ready
//           handshake, nibble partial products are shifted into a 2*DW
//           accumulator, and the result is offered on a second valid/ready
//           handshake.
//
// Ports   :
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mul8_seq_ctrl_if.slave (in_valid/in_ready/a/b,
//           out_valid/out_ready/product, busy)
//
// Timing  : accept at edge e0, DONE entered at edge eK (K = (DW/4)^2),
//           earliest return to IDLE at eK+1, next accept at eK+2.
// ----------------------------------------------------------------------------
module mul8_seq_ctrl
    import mul_pkg::*;
#(
    parameter int DW = 8
)
(
    input  logic         clk,
    input  logic         rst_n,
    mul8_seq_ctrl_if.slave bus
);

    localparam int NW = nib_count(DW);
    localparam int CW = nib_cnt_w(DW);
    localparam int AW = 2 * DW;
    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

    state_t          state;
    state_t          state_next;

    logic [DW-1:0]   a_r;
    logic [DW-1:0]   b_r;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;

    logic            accept;
    logic            release_out;
    logic            last_step;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [2*NIB_W-1:0] pp;
    logic [CW:0]        nib_sum;
    logic [CW+2:0]      shamt;
    logic [AW-1:0]      pp_ext;
    logic [AW-1:0]      pp_shifted;
    logic [AW-1:0]      acc_next;

    // Handshake qualifiers. in_ready/out_valid come straight from state,
    // so these are the only places inputs meet the state decode.
    assign accept      = (state == IDLE) && bus.in_valid;
    assign release_out = (state == DONE) && bus.out_ready;
    assign last_step   = (i == LAST_IDX) && (j == LAST_IDX);

    // Nibble selection from the latched operands for the current (i, j).
    always_comb begin
        a_nib = a_r[i*NIB_W +: NIB_W];
        b_nib = b_r[j*NIB_W +: NIB_W];
    end

    mul4_core u_core (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    // Weight of partial product (i, j) is 2^(4*(i+j)); the extra bit on
    // nib_sum keeps i+j from wrapping before it is scaled by four.
    always_comb begin
        nib_sum    = {1'b0, i} + {1'b0, j};
        shamt      = {nib_sum, 2'b00};
        pp_ext     = AW'(pp);
        pp_shifted = pp_ext << shamt;
        acc_next   = acc + pp_shifted;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs. All outputs depend on the
    // registered state alone.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and the nested (i outer, j inner)
    // slice counters. The accumulator is cleared only when a new pair is
    // taken, so the last product stays visible while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
        end else begin
            if (accept) begin
                a_r <= bus.a;
                b_r <= bus.b;
                acc <= '0;
                i   <= '0;
                j   <= '0;
            end else if (state == CALC) begin
                acc <= acc_next;
                if (j == LAST_IDX) begin
                    j <= '0;
                    i <= (i == LAST_IDX) ? '0 : i + CW'(1);
                end else begin
                    j <= j + CW'(1);
                end
            end
        end
    end

    assign bus.product = acc;

    // release_out is kept as a named qualifier for readability of the
    // DONE exit; it is consumed here so it is not an orphan net.
    logic unused_release;
    assign unused_release = release_out;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul8_seq_ctrl
//
// Purpose : Directed self-checking bench for mul8_seq_ctrl (DW = 8).
//           Each scenario task drives its own stimulus and compares the
//           DUT against hand-computed products and cycle counts.
// ----------------------------------------------------------------------------
module tb_mul8_seq_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mul8_seq_ctrl_if #(.DW(8)) bus ();

    mul8_seq_ctrl #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one full operation: present (av, bv), count cycles from the
    // accept edge to out_valid, capture the product, then take it.
    // hold_ready keeps out_ready high from before the accept.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input bit hold_ready,
                         output logic [15:0] prod, output int lat);
        int waited;
        bus.a         = av;
        bus.b         = bv;
        bus.in_valid  = 1'b1;
        bus.out_ready = hold_ready;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~av;
        bus.b        = ~bv;
        lat  = 0;
        prod = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat  = c;
                prod = bus.product;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL op_timeout: out_valid never rose for a=%h b=%h", av, bv);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] p;
        int          lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        rst_n         = 1'b0;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        @(negedge clk);
        rst_n = 1'b1;

        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_in_calc: got %b expected 1", bus.busy);
        end
        checks++;
        if (bus.product !== 16'h00E1) begin
            errors++;
            $display("[TB] FAIL first_partial: got %h expected 00e1", bus.product);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL async_reset_flags: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if (bus.product !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL async_reset_product: got %h expected 0000", bus.product);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd3, 8'd5, 1'b0, p, lat);
        checks++;
        if (p !== 16'h000F) begin
            errors++;
            $display("[TB] FAIL after_reset_3x5: got %h expected 000f", p);
        end
    endtask

    task automatic test_max();
        logic [15:0] p;
        int          lat;
        do_op(8'hFF, 8'hFF, 1'b1, p, lat);
        checks++;
        if (p !== 16'hFE01) begin
            errors++;
            $display("[TB] FAIL max_product: got %h expected fe01", p);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("[TB] FAIL max_latency: got %0d expected 4", lat);
        end
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL max_back_idle: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_mixed();
        logic [15:0] p;
        int          lat;
        do_op(8'h35, 8'hB2, 1'b0, p, lat);
        checks++;
        if (p !== 16'h24DA) begin
            errors++;
            $display("[TB] FAIL mixed_35xb2: got %h expected 24da", p);
        end
        do_op(8'hB2, 8'h35, 1'b0, p, lat);
        checks++;
        if (p !== 16'h24DA) begin
            errors++;
            $display("[TB] FAIL mixed_b2x35: got %h expected 24da", p);
        end
    endtask

    task automatic test_zero();
        logic [15:0] p;
        int          lat;
        do_op(8'h00, 8'hA7, 1'b0, p, lat);
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL zero_product: got %h expected 0000", p);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("[TB] FAIL zero_latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        bus.a         = 8'h12;
        bus.b         = 8'h34;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        // 0x12 * 0x34 = 18 * 52 = 936 = 0x03A8
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101 || bus.product !== 16'h03A8) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got v/r/b=%b prod=%h expected 101 prod=03a8",
                         c, {bus.out_valid, bus.in_ready, bus.busy}, bus.product);
            end
            bus.a        = 8'(c * 37 + 5);
            bus.b        = 8'(c * 91 + 3);
            bus.in_valid = ~bus.in_valid;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL bp_release: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.product !== 16'h03A8) begin
            errors++;
            $display("[TB] FAIL bp_stay_idle: got %b prod=%h expected 100 prod=03a8",
                     {bus.in_ready, bus.out_valid, bus.busy}, bus.product);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          acc_cyc [2];
        int          val_cyc [2];
        logic [15:0] res [2];
        int          n_acc;
        int          n_res;
        bit          ready_before;
        bus.a         = 8'd2;
        bus.b         = 8'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc   = 0;
        n_acc = 0;
        n_res = 0;
        ready_before = bus.in_ready;
        while (n_res < 2 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (ready_before && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                bus.a = 8'd20;
                bus.b = 8'd20;
            end
            if (bus.out_valid === 1'b1 && n_res < 2) begin
                res[n_res]     = bus.product;
                val_cyc[n_res] = cyc;
                n_res++;
            end
            ready_before = bus.in_ready;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (n_res != 2 || n_acc != 2) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: got %0d accepts %0d results expected 2 and 2", n_acc, n_res);
        end else begin
            checks++;
            if (res[0] !== 16'h0006) begin
                errors++;
                $display("[TB] FAIL b2b_first: got %h expected 0006", res[0]);
            end
            checks++;
            if (res[1] !== 16'h0190) begin
                errors++;
                $display("[TB] FAIL b2b_second: got %h expected 0190", res[1]);
            end
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 6) begin
                errors++;
                $display("[TB] FAIL b2b_spacing: got %0d expected 6", acc_cyc[1] - acc_cyc[0]);
            end
            checks++;
            if (val_cyc[0] - acc_cyc[0] != 4) begin
                errors++;
                $display("[TB] FAIL b2b_latency: got %0d expected 4", val_cyc[0] - acc_cyc[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_max();
        test_mixed();
        test_zero();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
